// File: rtl/jelly_wishbone_arbiter_n.sv
// N-channel Wishbone master arbiter (fixed priority or round-robin).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   inhibit           : blocks new grants; an owned cycle still completes
//   s_wb_*            : flattened slave-side buses, channel k at [k*W +: W]
//   m_wb_*            : shared Wishbone master port
//   grant_valid/index : current bus owner
module jelly_wishbone_arbiter_n #(
    parameter int NUM          = 4,
    parameter int WB_ADR_WIDTH = 30,
    parameter int WB_DAT_SIZE  = 2,
    parameter int WB_DAT_WIDTH = (8 << WB_DAT_SIZE),
    parameter int WB_SEL_WIDTH = (1 << WB_DAT_SIZE),
    parameter int ROUND_ROBIN  = 1,
    parameter int SEL_WIDTH    = (NUM <= 1) ? 1 : $clog2(NUM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inhibit,

    input  logic [NUM*WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [NUM*WB_DAT_WIDTH-1:0] s_wb_dat_i,
    output logic [NUM*WB_DAT_WIDTH-1:0] s_wb_dat_o,
    input  logic [NUM-1:0]              s_wb_we_i,
    input  logic [NUM*WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic [NUM-1:0]              s_wb_stb_i,
    output logic [NUM-1:0]              s_wb_ack_o,

    output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
    input  logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o,
    output logic                        m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o,
    output logic                        m_wb_stb_o,
    input  logic                        m_wb_ack_i,

    output logic                        grant_valid,
    output logic [SEL_WIDTH-1:0]        grant_index
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [SEL_WIDTH-1:0] grant_index_q;
    logic [SEL_WIDTH-1:0] grant_index_d;
    logic [SEL_WIDTH-1:0] ptr_q;
    logic [SEL_WIDTH-1:0] ptr_d;

    logic                 win_valid;
    logic [SEL_WIDTH-1:0] win_index;
    logic                 cur_stb;
    logic [SEL_WIDTH-1:0] mux_index;

    // ------------------------------------------------------------
    // Winner selection.
    // Round-robin is done as two upward scans: first channels at or
    // above the pointer, then the wrapped part from channel 0.
    // With fixed priority the first scan already covers every channel,
    // so the lowest-numbered requester wins.
    // ------------------------------------------------------------
    always_comb begin
        win_valid = 1'b0;
        win_index = '0;
        for (int j = 0; j < NUM; j++) begin
            if (!win_valid && s_wb_stb_i[j] &&
                (ROUND_ROBIN == 0 || SEL_WIDTH'(j) >= ptr_q)) begin
                win_valid = 1'b1;
                win_index = SEL_WIDTH'(j);
            end
        end
        for (int j = 0; j < NUM; j++) begin
            if (!win_valid && s_wb_stb_i[j]) begin
                win_valid = 1'b1;
                win_index = SEL_WIDTH'(j);
            end
        end
    end

    // Strobe of the current owner (meaningful only while BUSY).
    always_comb begin
        cur_stb = 1'b0;
        for (int j = 0; j < NUM; j++) begin
            if (SEL_WIDTH'(j) == grant_index_q) begin
                cur_stb = s_wb_stb_i[j];
            end
        end
    end

    // ------------------------------------------------------------
    // State register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_index_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_index_q <= grant_index_d;
        end
    end

    // The pointer only exists when there is something to rotate over.
    generate
        if (NUM > 1) begin : g_ptr
            always_ff @(posedge clk) begin
                if (reset) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_no_ptr
            assign ptr_q = '0;
        end
    endgenerate

    // ------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        ptr_d         = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (!inhibit && win_valid) begin
                    state_d       = BUSY;
                    grant_index_d = win_index;
                end
            end
            BUSY: begin
                if (m_wb_ack_i) begin
                    // Completed transfer: the next scan starts just
                    // past the channel that was served.
                    state_d = IDLE;
                    if (grant_index_q == SEL_WIDTH'(NUM - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_index_q + 1'b1;
                    end
                end else if (!cur_stb) begin
                    // Owner withdrew its strobe: release, keep pointer.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------
    assign grant_valid = (state_q == BUSY);
    assign grant_index = grant_index_q;

    // Idle master outputs follow channel 0.
    assign mux_index = grant_valid ? grant_index_q : '0;

    always_comb begin
        m_wb_adr_o = s_wb_adr_i[0 +: WB_ADR_WIDTH];
        m_wb_dat_o = s_wb_dat_i[0 +: WB_DAT_WIDTH];
        m_wb_we_o  = s_wb_we_i[0];
        m_wb_sel_o = s_wb_sel_i[0 +: WB_SEL_WIDTH];
        for (int j = 0; j < NUM; j++) begin
            if (SEL_WIDTH'(j) == mux_index) begin
                m_wb_adr_o = s_wb_adr_i[j*WB_ADR_WIDTH +: WB_ADR_WIDTH];
                m_wb_dat_o = s_wb_dat_i[j*WB_DAT_WIDTH +: WB_DAT_WIDTH];
                m_wb_we_o  = s_wb_we_i[j];
                m_wb_sel_o = s_wb_sel_i[j*WB_SEL_WIDTH +: WB_SEL_WIDTH];
            end
        end
    end

    assign m_wb_stb_o = cur_stb & grant_valid;

    // Ack is routed only to the owner; after a release it goes nowhere.
    always_comb begin
        s_wb_ack_o = '0;
        for (int j = 0; j < NUM; j++) begin
            if (SEL_WIDTH'(j) == grant_index_q) begin
                s_wb_ack_o[j] = m_wb_ack_i & grant_valid;
            end
        end
    end

    // Read data is broadcast; only the acked channel consumes it.
    always_comb begin
        s_wb_dat_o = '0;
        for (int j = 0; j < NUM; j++) begin
            s_wb_dat_o[j*WB_DAT_WIDTH +: WB_DAT_WIDTH] = m_wb_dat_i;
        end
    end

endmodule

// File: tb/tb_jelly_wishbone_arbiter_n.sv
// Bench for jelly_wishbone_arbiter_n: one round-robin and one
// fixed-priority instance driven from the same slave-side stimulus.
module tb_jelly_wishbone_arbiter_n;

    localparam int NUM = 4;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int IW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              inhibit;
    logic [NUM*AW-1:0] s_adr;
    logic [NUM*DW-1:0] s_dat;
    logic [NUM-1:0]    s_we;
    logic [NUM*SW-1:0] s_sel;
    logic [NUM-1:0]    s_stb;
    logic [DW-1:0]     m_dat_i;
    logic              auto_ack;
    logic              man_ack;

    logic [NUM*DW-1:0] r_sdat, f_sdat;
    logic [NUM-1:0]    r_sack, f_sack;
    logic [AW-1:0]     r_adr, f_adr;
    logic [DW-1:0]     r_dat, f_dat;
    logic              r_we, f_we;
    logic [SW-1:0]     r_sel, f_sel;
    logic              r_stb, f_stb;
    logic              r_ack, f_ack;
    logic              r_gv, f_gv;
    logic [IW-1:0]     r_gi, f_gi;

    // Slave model: either acks every strobed cycle or follows man_ack.
    assign r_ack = auto_ack ? r_stb : man_ack;
    assign f_ack = auto_ack ? f_stb : man_ack;

    jelly_wishbone_arbiter_n #(.NUM(NUM), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset), .inhibit(inhibit),
        .s_wb_adr_i(s_adr), .s_wb_dat_i(s_dat), .s_wb_dat_o(r_sdat),
        .s_wb_we_i(s_we), .s_wb_sel_i(s_sel), .s_wb_stb_i(s_stb),
        .s_wb_ack_o(r_sack),
        .m_wb_adr_o(r_adr), .m_wb_dat_i(m_dat_i), .m_wb_dat_o(r_dat),
        .m_wb_we_o(r_we), .m_wb_sel_o(r_sel), .m_wb_stb_o(r_stb),
        .m_wb_ack_i(r_ack),
        .grant_valid(r_gv), .grant_index(r_gi)
    );

    jelly_wishbone_arbiter_n #(.NUM(NUM), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset), .inhibit(inhibit),
        .s_wb_adr_i(s_adr), .s_wb_dat_i(s_dat), .s_wb_dat_o(f_sdat),
        .s_wb_we_i(s_we), .s_wb_sel_i(s_sel), .s_wb_stb_i(s_stb),
        .s_wb_ack_o(f_sack),
        .m_wb_adr_o(f_adr), .m_wb_dat_i(m_dat_i), .m_wb_dat_o(f_dat),
        .m_wb_we_o(f_we), .m_wb_sel_o(f_sel), .m_wb_stb_o(f_stb),
        .m_wb_ack_i(f_ack),
        .grant_valid(f_gv), .grant_index(f_gi)
    );

    int checks   = 0;
    int failures = 0;

    // Expected ack vectors, pushed when stimulus is applied.
    logic [NUM-1:0] exp_rr[$];
    logic [NUM-1:0] exp_fp[$];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s_stb    = '0;
        man_ack  = 1'b0;
        auto_ack = 1'b0;
        inhibit  = 1'b0;
        cyc();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({r_gv, f_gv} !== 2'b00) begin
            failures++;
            $display("FAIL reset_gv got=%b exp=00", {r_gv, f_gv});
        end
        checks++;
        if ({r_gi, f_gi} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gi got=%h exp=0", {r_gi, f_gi});
        end
        checks++;
        if ({r_stb, f_stb, r_sack, f_sack} !== 10'b0) begin
            failures++;
            $display("FAIL reset_stb_ack got=%b exp=0",
                     {r_stb, f_stb, r_sack, f_sack});
        end
    endtask

    task automatic test_single();
        logic [NUM-1:0] e;
        do_reset();
        s_stb = 4'b0100;
        exp_rr.push_back(4'b0100);
        exp_fp.push_back(4'b0100);
        cyc();
        checks++;
        if (r_gv !== 1'b1 || r_gi !== 2'd2 || f_gv !== 1'b1 || f_gi !== 2'd2) begin
            failures++;
            $display("FAIL single_grant got=%b%0d/%b%0d exp=1 2",
                     r_gv, r_gi, f_gv, f_gi);
        end
        checks++;
        if (r_stb !== 1'b1 || r_adr !== 30'h102 || r_dat !== 32'hD000_0002
            || r_we !== 1'b0 || r_sel !== 4'h2) begin
            failures++;
            $display("FAIL single_mux got=%b %h %h %b %h exp=1 102 d0000002 0 2",
                     r_stb, r_adr, r_dat, r_we, r_sel);
        end
        checks++;
        if (r_sack !== 4'b0000) begin
            failures++;
            $display("FAIL single_noack got=%b exp=0000", r_sack);
        end
        man_ack = 1'b1;
        m_dat_i = 32'hCAFE_F00D;
        #1;
        e = exp_rr.pop_front();
        checks++;
        if (r_sack !== e) begin
            failures++;
            $display("FAIL single_ack_rr got=%b exp=%b", r_sack, e);
        end
        e = exp_fp.pop_front();
        checks++;
        if (f_sack !== e) begin
            failures++;
            $display("FAIL single_ack_fp got=%b exp=%b", f_sack, e);
        end
        checks++;
        if (r_sdat[2*DW +: DW] !== 32'hCAFE_F00D
            || f_sdat[0 +: DW] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL single_rdata got=%h exp=cafef00d", r_sdat[2*DW +: DW]);
        end
        cyc();
        checks++;
        if (r_gv !== 1'b0 || f_gv !== 1'b0 || r_stb !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got=%b%b%b exp=000", r_gv, f_gv, r_stb);
        end
        man_ack = 1'b0;
        s_stb   = '0;
    endtask

    task automatic test_arbitration();
        int cnt_rr[NUM];
        int cnt_fp[NUM];
        logic [NUM-1:0] e;
        for (int k = 0; k < NUM; k++) begin
            cnt_rr[k] = 0;
            cnt_fp[k] = 0;
        end
        do_reset();
        s_stb    = 4'b1111;
        auto_ack = 1'b1;
        exp_rr.push_back(4'b0001);
        exp_rr.push_back(4'b0010);
        exp_rr.push_back(4'b0100);
        exp_rr.push_back(4'b1000);
        exp_rr.push_back(4'b0001);
        for (int k = 0; k < 5; k++) exp_fp.push_back(4'b0001);
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (r_sack !== 4'b0000) begin
                e = (exp_rr.size() > 0) ? exp_rr.pop_front() : 4'b0000;
                checks++;
                if (r_sack !== e) begin
                    failures++;
                    $display("FAIL rr_order cyc=%0d got=%b exp=%b", c, r_sack, e);
                end
            end
            if (f_sack !== 4'b0000) begin
                e = (exp_fp.size() > 0) ? exp_fp.pop_front() : 4'b0000;
                checks++;
                if (f_sack !== e) begin
                    failures++;
                    $display("FAIL fp_order cyc=%0d got=%b exp=%b", c, f_sack, e);
                end
            end
            if (c < 8) begin
                for (int k = 0; k < NUM; k++) begin
                    cnt_rr[k] += int'(r_sack[k]);
                    cnt_fp[k] += int'(f_sack[k]);
                end
            end
        end
        checks++;
        if (exp_rr.size() != 0 || exp_fp.size() != 0) begin
            failures++;
            $display("FAIL arb_missing got=%0d/%0d left exp=0",
                     exp_rr.size(), exp_fp.size());
            exp_rr.delete();
            exp_fp.delete();
        end
        checks++;
        if (cnt_rr[0] != 1 || cnt_rr[1] != 1 || cnt_rr[2] != 1 || cnt_rr[3] != 1) begin
            failures++;
            $display("FAIL rr_fair got=%0d,%0d,%0d,%0d exp=1,1,1,1",
                     cnt_rr[0], cnt_rr[1], cnt_rr[2], cnt_rr[3]);
        end
        checks++;
        if (cnt_fp[0] != 4 || cnt_fp[1] != 0 || cnt_fp[2] != 0 || cnt_fp[3] != 0) begin
            failures++;
            $display("FAIL fp_prio got=%0d,%0d,%0d,%0d exp=4,0,0,0",
                     cnt_fp[0], cnt_fp[1], cnt_fp[2], cnt_fp[3]);
        end
        auto_ack = 1'b0;
        s_stb    = '0;
    endtask

    task automatic test_inhibit();
        int bad;
        do_reset();
        inhibit = 1'b1;
        s_stb   = 4'b0010;
        bad     = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (r_gv || f_gv || r_stb || f_stb) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL inhibit_block got=%0d granted cycles exp=0", bad);
        end
        s_stb   = '0;
        inhibit = 1'b0;
        cyc();
        s_stb = 4'b1000;
        cyc();
        inhibit = 1'b1;
        checks++;
        if (r_gi !== 2'd3 || f_gi !== 2'd3 || r_gv !== 1'b1 || f_gv !== 1'b1) begin
            failures++;
            $display("FAIL inhibit_ch3_grant got=%0d/%0d exp=3", r_gi, f_gi);
        end
        cyc();
        checks++;
        if (r_gv !== 1'b1 || f_gv !== 1'b1 || r_stb !== 1'b1) begin
            failures++;
            $display("FAIL inhibit_busy_hold got=%b%b%b exp=111", r_gv, f_gv, r_stb);
        end
        man_ack = 1'b1;
        #1;
        checks++;
        if (r_sack !== 4'b1000 || f_sack !== 4'b1000) begin
            failures++;
            $display("FAIL inhibit_ack got=%b/%b exp=1000", r_sack, f_sack);
        end
        cyc();
        man_ack = 1'b0;
        s_stb   = '0;
        inhibit = 1'b0;
        checks++;
        if (r_gv !== 1'b0 || f_gv !== 1'b0) begin
            failures++;
            $display("FAIL inhibit_done got=%b%b exp=00", r_gv, f_gv);
        end
    endtask

    task automatic test_abort();
        do_reset();
        s_stb = 4'b0010;
        cyc();
        checks++;
        if (r_gi !== 2'd1 || r_gv !== 1'b1) begin
            failures++;
            $display("FAIL abort_grant got=%b %0d exp=1 1", r_gv, r_gi);
        end
        s_stb = 4'b0000;
        #1;
        checks++;
        if (r_stb !== 1'b0 || f_stb !== 1'b0) begin
            failures++;
            $display("FAIL abort_stb got=%b%b exp=00", r_stb, f_stb);
        end
        cyc();
        checks++;
        if (r_gv !== 1'b0 || f_gv !== 1'b0) begin
            failures++;
            $display("FAIL abort_release got=%b%b exp=00", r_gv, f_gv);
        end
        man_ack = 1'b1;
        #1;
        checks++;
        if (r_sack !== 4'b0000 || f_sack !== 4'b0000) begin
            failures++;
            $display("FAIL abort_stray_ack got=%b/%b exp=0000", r_sack, f_sack);
        end
        man_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_stb = 4'b0001;
        cyc();
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        s_stb   = 4'b0100;
        cyc();
        checks++;
        if (r_gi !== 2'd2 || r_gv !== 1'b1) begin
            failures++;
            $display("FAIL rmid_setup got=%b %0d exp=1 2", r_gv, r_gi);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (r_gv !== 1'b0 || r_stb !== 1'b0 || f_gv !== 1'b0 || f_stb !== 1'b0) begin
            failures++;
            $display("FAIL rmid_drop got=%b%b%b%b exp=0000", r_gv, r_stb, f_gv, f_stb);
        end
        reset = 1'b0;
        s_stb = 4'b0011;
        cyc();
        checks++;
        if (r_gi !== 2'd0 || r_gv !== 1'b1) begin
            failures++;
            $display("FAIL rmid_ptr0 got=%b %0d exp=1 0", r_gv, r_gi);
        end
        s_stb = '0;
        cyc();
    endtask

    initial begin
        reset    = 1'b1;
        inhibit  = 1'b0;
        s_stb    = '0;
        s_we     = 4'b1010;
        man_ack  = 1'b0;
        auto_ack = 1'b0;
        m_dat_i  = '0;
        for (int k = 0; k < NUM; k++) begin
            s_adr[k*AW +: AW] = 30'h100 + AW'(k);
            s_dat[k*DW +: DW] = 32'hD000_0000 + DW'(k);
            s_sel[k*SW +: SW] = SW'(k);
        end
        test_reset();
        test_single();
        test_arbitration();
        test_inhibit();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
